// File: rtl/argmax_classifier.sv
// Argmax output stage: captures N_CLASSES signed scores on start and scans them one per cycle.
// Optional second-best tracking and a margin output are enabled with `define ARGMAX_MARGIN_EN.
module argmax_classifier #(
    parameter int N_CLASSES = 10,
    parameter int DATA_W    = 32,
    parameter int IDX_W     = 4
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          start,
    input  logic [N_CLASSES*DATA_W-1:0]   scores,
    output logic                          busy,
    output logic                          done,
    output logic [IDX_W-1:0]              class_idx,
    output logic [DATA_W-1:0]             max_score
`ifdef ARGMAX_MARGIN_EN
    ,
    output logic [DATA_W:0]               margin
`endif
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SCAN,
        S_DONE
    } state_e;

    localparam logic [IDX_W-1:0] LAST_PTR = IDX_W'(N_CLASSES - 1);

    state_e                 state_q, state_d;
    logic [DATA_W-1:0]      score_buf_q [N_CLASSES];
    logic [DATA_W-1:0]      score_buf_d [N_CLASSES];
    logic [IDX_W-1:0]       ptr_q, ptr_d;
    logic [DATA_W-1:0]      run_max_q, run_max_d;
    logic [IDX_W-1:0]       run_idx_q, run_idx_d;
    logic                   busy_q, busy_d;
    logic                   done_q, done_d;
    logic [IDX_W-1:0]       class_idx_q, class_idx_d;
    logic [DATA_W-1:0]      max_score_q, max_score_d;

    // One scan step: the candidate at ptr against the running maximum.
    logic [DATA_W-1:0]      cand;
    logic                   cand_gt_max;
    logic [DATA_W-1:0]      step_max;
    logic [IDX_W-1:0]       step_idx;

`ifdef ARGMAX_MARGIN_EN
    localparam logic [DATA_W-1:0] MOST_NEG = {1'b1, {(DATA_W-1){1'b0}}};

    logic [DATA_W-1:0]      second_q, second_d;
    logic [DATA_W:0]        margin_q, margin_d;
    logic                   cand_gt_second;
    logic [DATA_W-1:0]      step_second;
`endif

    always_comb begin
        cand        = score_buf_q[ptr_q];
        cand_gt_max = $signed(cand) > $signed(run_max_q);
        step_max    = cand_gt_max ? cand  : run_max_q;
        step_idx    = cand_gt_max ? ptr_q : run_idx_q;
`ifdef ARGMAX_MARGIN_EN
        cand_gt_second = $signed(cand) > $signed(second_q);
        // Top-2 rule: a new maximum demotes the old one to second place.
        if (cand_gt_max) begin
            step_second = run_max_q;
        end else if (cand_gt_second) begin
            step_second = cand;
        end else begin
            step_second = second_q;
        end
`endif
    end

    // NOTE: every variable assigned here gets a default first so no latch is inferred.
    always_comb begin
        state_d     = state_q;
        score_buf_d = score_buf_q;
        ptr_d       = ptr_q;
        run_max_d   = run_max_q;
        run_idx_d   = run_idx_q;
        busy_d      = 1'b0;
        done_d      = 1'b0;
        class_idx_d = class_idx_q;
        max_score_d = max_score_q;
`ifdef ARGMAX_MARGIN_EN
        second_d    = second_q;
        margin_d    = margin_q;
`endif

        case (state_q)
            S_IDLE, S_DONE: begin
                state_d = S_IDLE;
                if (start) begin
                    for (int k = 0; k < N_CLASSES; k++) begin
                        score_buf_d[k] = scores[k*DATA_W +: DATA_W];
                    end
                    run_max_d = scores[0 +: DATA_W];
                    run_idx_d = '0;
                    ptr_d     = IDX_W'(1);
                    busy_d    = 1'b1;
                    state_d   = S_SCAN;
`ifdef ARGMAX_MARGIN_EN
                    second_d  = MOST_NEG;
`endif
                end
            end

            S_SCAN: begin
                run_max_d = step_max;
                run_idx_d = step_idx;
                ptr_d     = ptr_q + IDX_W'(1);
`ifdef ARGMAX_MARGIN_EN
                second_d  = step_second;
`endif
                if (ptr_q == LAST_PTR) begin
                    class_idx_d = step_idx;
                    max_score_d = step_max;
                    done_d      = 1'b1;
                    state_d     = S_DONE;
`ifdef ARGMAX_MARGIN_EN
                    // Sign-extend both operands so the difference can never overflow.
                    margin_d    = {step_max[DATA_W-1], step_max}
                                - {step_second[DATA_W-1], step_second};
`endif
                end else begin
                    busy_d = 1'b1;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // NOTE: state uses non-blocking assignments; the score buffer is on the async reset
    // as well, so nothing captured before a reset can leak into a later result.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            for (int k = 0; k < N_CLASSES; k++) begin
                score_buf_q[k] <= '0;
            end
            ptr_q       <= '0;
            run_max_q   <= '0;
            run_idx_q   <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            class_idx_q <= '0;
            max_score_q <= '0;
`ifdef ARGMAX_MARGIN_EN
            second_q    <= '0;
            margin_q    <= '0;
`endif
        end else begin
            state_q     <= state_d;
            score_buf_q <= score_buf_d;
            ptr_q       <= ptr_d;
            run_max_q   <= run_max_d;
            run_idx_q   <= run_idx_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            class_idx_q <= class_idx_d;
            max_score_q <= max_score_d;
`ifdef ARGMAX_MARGIN_EN
            second_q    <= second_d;
            margin_q    <= margin_d;
`endif
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign class_idx = class_idx_q;
    assign max_score = max_score_q;
`ifdef ARGMAX_MARGIN_EN
    assign margin    = margin_q;
`endif

endmodule

// File: tb/tb_argmax_classifier.sv
// Self-checking bench for argmax_classifier: directed cases plus random score sets
// compared against a first-index-of-maximum reference model.
module tb_argmax_classifier;

    localparam int N    = 10;
    localparam int W    = 32;
    localparam int IW   = 4;
    localparam int MAXE = 40;

    typedef struct {
        int     idx;
        longint mx;
        longint mg;
    } exp_t;

    logic           clk = 1'b0;
    logic           reset;
    logic           start;
    logic [N*W-1:0] scores;
    logic           busy;
    logic           done;
    logic [IW-1:0]  class_idx;
    logic [W-1:0]   max_score;
`ifdef ARGMAX_MARGIN_EN
    logic [W:0]     margin;
`endif

    int   checks = 0;
    int   errors = 0;
    exp_t last_exp;

    always #5 clk = ~clk;

    argmax_classifier #(
        .N_CLASSES(N),
        .DATA_W   (W),
        .IDX_W    (IW)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .scores   (scores),
        .busy     (busy),
        .done     (done),
        .class_idx(class_idx),
        .max_score(max_score)
`ifdef ARGMAX_MARGIN_EN
        ,
        .margin   (margin)
`endif
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference: maximum value, first index holding it, and max minus the runner-up
    // (runner-up equals the maximum when it occurs more than once).
    function automatic exp_t model(input logic [N*W-1:0] v);
        exp_t   e;
        longint s [N];
        longint second;
        int     cnt;
        for (int k = 0; k < N; k++) s[k] = longint'($signed(v[k*W +: W]));
        e.mx = s[0];
        for (int k = 1; k < N; k++) if (s[k] > e.mx) e.mx = s[k];
        e.idx = -1;
        cnt   = 0;
        for (int k = 0; k < N; k++) begin
            if (s[k] == e.mx) begin
                cnt++;
                if (e.idx < 0) e.idx = k;
            end
        end
        second = -(longint'(1) << (W - 1));
        if (cnt > 1) begin
            second = e.mx;
        end else begin
            for (int k = 0; k < N; k++) if (s[k] < e.mx && s[k] > second) second = s[k];
        end
        e.mg = e.mx - second;
        return e;
    endfunction

    function automatic logic [N*W-1:0] pack(input int s [N]);
        logic [N*W-1:0] v;
        for (int k = 0; k < N; k++) v[k*W +: W] = W'(s[k]);
        return v;
    endfunction

    function automatic logic [N*W-1:0] rand_vec(input bit narrow);
        logic [N*W-1:0] v;
        for (int k = 0; k < N; k++) begin
            if (narrow) v[k*W +: W] = W'(int'($urandom_range(0, 6)) - 3);
            else        v[k*W +: W] = W'($urandom);
        end
        return v;
    endfunction

    function automatic logic [63:0] sx(input logic [W-1:0] x);
        return {{(64-W){x[W-1]}}, x};
    endfunction

    // Pulse start with v in the current cycle and follow the scan until done.
    // inject_at > 0 raises start again (with junk scores) while the scan is busy.
    task automatic do_scan(input logic [N*W-1:0] v, input string tag, input int inject_at);
        exp_t          e;
        logic [IW-1:0] prev_idx;
        logic [W-1:0]  prev_max;
        int            edges;
        int            busy_cyc;
        bit            early;
        e        = model(v);
        prev_idx = class_idx;
        prev_max = max_score;
        start    = 1'b1;
        scores   = v;
        @(posedge clk);
        #1;
        start    = 1'b0;
        scores   = rand_vec(1'b0);
        edges    = 1;
        busy_cyc = 0;
        early    = 1'b0;
        while (done !== 1'b1 && edges < MAXE) begin
            if (busy === 1'b1) busy_cyc++;
            if (class_idx !== prev_idx || max_score !== prev_max) early = 1'b1;
            if (edges == inject_at) begin
                start  = 1'b1;
                scores = rand_vec(1'b0);
            end
            @(posedge clk);
            #1;
            start = 1'b0;
            edges++;
        end
        check({tag, ".latency"}, 64'(edges), 64'(N));
        check({tag, ".busy_cycles"}, 64'(busy_cyc), 64'(N - 1));
        check({tag, ".held_during_scan"}, 64'(early), 64'(0));
        check({tag, ".busy_in_done"}, 64'(busy), 64'(0));
        check({tag, ".class_idx"}, 64'(class_idx), 64'(e.idx));
        check({tag, ".max_score"}, sx(max_score), 64'(e.mx));
`ifdef ARGMAX_MARGIN_EN
        check({tag, ".margin"}, 64'(margin), 64'(e.mg));
`endif
        last_exp = e;
    endtask

    task automatic idle_check(input string tag);
        @(posedge clk);
        #1;
        check({tag, ".done_single"}, 64'(done), 64'(0));
        check({tag, ".idle_busy"}, 64'(busy), 64'(0));
        check({tag, ".idx_held"}, 64'(class_idx), 64'(last_exp.idx));
        check({tag, ".max_held"}, sx(max_score), 64'(last_exp.mx));
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, ".busy"}, 64'(busy), 64'(0));
        check({tag, ".done"}, 64'(done), 64'(0));
        check({tag, ".class_idx"}, 64'(class_idx), 64'(0));
        check({tag, ".max_score"}, 64'(max_score), 64'(0));
`ifdef ARGMAX_MARGIN_EN
        check({tag, ".margin"}, 64'(margin), 64'(0));
`endif
    endtask

    initial begin
        int             t1 [N];
        int             t2 [N];
        logic [N*W-1:0] v;
        logic [N*W-1:0] va;
        logic [N*W-1:0] vb;
        int             pulses;

        t1 = '{5, -3, 12, 7, 0, 1, 2, 3, 4, 11};
        for (int k = 0; k < N; k++) t2[k] = -100;

        reset  = 1'b1;
        start  = 1'b0;
        scores = '0;
        #1;
        check_reset_outputs("por");
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;

        // Directed: mixed scores, uniform ties, signed extremes.
        do_scan(pack(t1), "mixed", 0);
        check("mixed.spec_idx", 64'(class_idx), 64'(2));
        check("mixed.spec_max", sx(max_score), 64'(12));
        idle_check("mixed");

        do_scan(pack(t2), "ties", 0);
        check("ties.spec_idx", 64'(class_idx), 64'(0));
        idle_check("ties");

        v = '0;
        v[9*W +: W] = 32'h7FFF_FFFF;
        v[0 +: W]   = 32'h8000_0000;
        do_scan(v, "extreme", 0);
        check("extreme.spec_idx", 64'(class_idx), 64'(9));
        idle_check("extreme");

        // A second start three cycles into a scan must be ignored.
        do_scan(rand_vec(1'b0), "ignore", 3);
        pulses = 0;
        repeat (12) begin
            @(posedge clk);
            #1;
            if (done === 1'b1) pulses++;
        end
        check("ignore.extra_done", 64'(pulses), 64'(0));
        check("ignore.idx_unchanged", 64'(class_idx), 64'(last_exp.idx));
        check("ignore.max_unchanged", sx(max_score), 64'(last_exp.mx));

        // Asynchronous reset five cycles into a scan.
        start  = 1'b1;
        scores = rand_vec(1'b0);
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (4) @(posedge clk);
        #2;
        reset = 1'b1;
        #1;
        check_reset_outputs("midreset");
        repeat (2) @(posedge clk);
        #1;
        reset  = 1'b0;
        pulses = 0;
        repeat (15) begin
            @(posedge clk);
            #1;
            if (done === 1'b1 || busy === 1'b1) pulses++;
        end
        check("midreset.no_activity", 64'(pulses), 64'(0));
        check("midreset.idx_zero", 64'(class_idx), 64'(0));
        do_scan(pack(t1), "after_reset", 0);
        idle_check("after_reset");

        // Back-to-back: second start lands in the DONE cycle.
        va = pack(t1);
        vb = pack(t2);
        vb[7*W +: W] = 32'd50;
        do_scan(va, "b2b_first", 0);
        do_scan(vb, "b2b_second", 0);
        check("b2b.spec_idx", 64'(class_idx), 64'(7));
        idle_check("b2b");

        // Random score sets; narrow ranges exercise ties, odd iterations run back-to-back.
        for (int i = 0; i < 16; i++) begin
            do_scan(rand_vec(i[1]), $sformatf("rand%0d", i), 0);
            if (i[0]) idle_check($sformatf("rand%0d", i));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
